// File: rtl/regfile_wr_arb_if.sv
// Bus bundle for regfile_wr_arb: pipeline W-stage request, multi-cycle result
// handshake, hazard queries and the register-file write port.
interface regfile_wr_arb_if;
   logic        p_wr;
   logic [4:0]  p_dst;
   logic [31:0] p_data;
   logic        m_valid;
   logic [4:0]  m_dst;
   logic [31:0] m_data;
   logic        m_ready;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        rs_pend;
   logic        rt_pend;
   logic        p_stall;
   logic        wr;
   logic [4:0]  RegWrDst_W;
   logic [31:0] wd;

   modport master (
      output p_wr, p_dst, p_data, m_valid, m_dst, m_data, rs, rt,
      input  m_ready, rs_pend, rt_pend, p_stall, wr, RegWrDst_W, wd
   );

   modport slave (
      input  p_wr, p_dst, p_data, m_valid, m_dst, m_data, rs, rt,
      output m_ready, rs_pend, rt_pend, p_stall, wr, RegWrDst_W, wd
   );
endinterface

// File: rtl/regfile_wr_arb.sv
// Register-file write-port arbiter between the W-stage pipeline and a queue of
// multi-cycle results. Define REGFILE_WR_ARB_STARVE_GUARD_EN for the starvation guard.
module regfile_wr_arb #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input logic             clk,
   input logic             rst,
   regfile_wr_arb_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, off;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       dst_q  [FIFO_DEPTH];
   logic [4:0]       dst_d  [FIFO_DEPTH];
   logic [31:0]      data_q [FIFO_DEPTH];
   logic [31:0]      data_d [FIFO_DEPTH];

   logic empty, full, p_req, waw_hit, rs_hit, rt_hit, starve_force;
   logic stall, head_gnt, pipe_gnt, enq;
   logic        wr_o;
   logic [4:0]  dst_o;
   logic [31:0] wd_o;

   assign empty = (cnt_q == '0);
   assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign p_req = bus.p_wr && (bus.p_dst != 5'd0);
   assign enq   = bus.m_valid && !full && (bus.m_dst != 5'd0);

   // An entry is live when its distance from head is below the occupancy.
   always_comb begin
      off     = '0;
      waw_hit = 1'b0;
      rs_hit  = 1'b0;
      rt_hit  = 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
         off = PTR_W'(i) - head_q;
         if (CNT_W'(off) < cnt_q) begin
            if (dst_q[i] == bus.p_dst) waw_hit = 1'b1;
            if (dst_q[i] == bus.rs)    rs_hit  = 1'b1;
            if (dst_q[i] == bus.rt)    rt_hit  = 1'b1;
         end
      end
   end

`ifdef REGFILE_WR_ARB_STARVE_GUARD_EN
   localparam int unsigned SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_q, starve_d;

   assign starve_force = !empty && (starve_q >= SW'(STARVE_MAX));

   always_comb begin
      starve_d = starve_q;
      if (empty || head_gnt)                starve_d = '0;
      else if (starve_q < SW'(STARVE_MAX))  starve_d = starve_q + SW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_q <= '0;
      else     starve_q <= starve_d;
   end
`else
   assign starve_force = 1'b0;
`endif

   assign stall    = (p_req && waw_hit) || starve_force;
   // Outputs are gated by rst so nothing is written while reset is held.
   assign head_gnt = !rst && !empty && (stall || !p_req);
   assign pipe_gnt = !rst && !stall && p_req;

   always_comb begin
      wr_o  = 1'b0;
      dst_o = '0;
      wd_o  = '0;
      if (head_gnt) begin
         wr_o  = 1'b1;
         dst_o = dst_q[head_q];
         wd_o  = data_q[head_q];
      end else if (pipe_gnt) begin
         wr_o  = 1'b1;
         dst_o = bus.p_dst;
         wd_o  = bus.p_data;
      end
   end

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      dst_d  = dst_q;
      data_d = data_q;
      if (enq) begin
         dst_d[tail_q]  = bus.m_dst;
         data_d[tail_q] = bus.m_data;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (head_gnt) head_d = head_q + PTR_W'(1);
      case ({enq, head_gnt})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            dst_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
         dst_q  <= dst_d;
         data_q <= data_d;
      end
   end

   assign bus.m_ready    = !full;
   assign bus.p_stall    = stall;
   assign bus.rs_pend    = (bus.rs != 5'd0) && rs_hit;
   assign bus.rt_pend    = (bus.rt != 5'd0) && rt_hit;
   assign bus.wr         = wr_o;
   assign bus.RegWrDst_W = dst_o;
   assign bus.wd         = wd_o;

endmodule
